// File: rtl/arb_serial_32_8.sv
// Two-requester round-robin arbiter feeding a 32-bit to 8-bit serializer.
// Words go out MSB byte first; a new word can be granted while the last byte is on data_out.
module arb_serial_32_8 (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        valid_in0,
    input  logic [31:0] data_in0,
    input  logic        valid_in1,
    input  logic [31:0] data_in1,
    output logic        accept0,
    output logic        accept1,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        first_out,
    output logic        source_out,
    output logic        busy
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e      state;
    logic [23:0] hold_q, hold_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        first_q, first_d;
    logic        source_q, source_d;
    logic        can_accept;
    logic        grant0, grant1;

    // The FSM state is implied by the remaining-byte count.
    assign state = (cnt_q != 2'd0) ? StSend : StIdle;

    always_comb begin
        can_accept = reset_L && (state == StIdle);
        grant0     = can_accept && valid_in0 && (!valid_in1 || !prio_q);
        grant1     = can_accept && valid_in1 && (!valid_in0 || prio_q);
    end

    always_comb begin
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        prio_d   = prio_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        first_d  = 1'b0;
        source_d = source_q;
        unique case (state)
            StIdle: begin
                if (grant0 || grant1) begin
                    data_d   = grant1 ? data_in1[31:24] : data_in0[31:24];
                    hold_d   = grant1 ? data_in1[23:0]  : data_in0[23:0];
                    cnt_d    = 2'd3;
                    valid_d  = 1'b1;
                    first_d  = 1'b1;
                    source_d = grant1;
                    // Point away from whoever just won, even if it was alone.
                    prio_d   = ~grant1;
                end
            end
            StSend: begin
                data_d  = hold_q[23:16];
                hold_d  = {hold_q[15:0], 8'h00};
                cnt_d   = cnt_q - 2'd1;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            hold_q   <= 24'h000000;
            cnt_q    <= 2'd0;
            prio_q   <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            source_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            prio_q   <= prio_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            source_q <= source_d;
        end
    end

    assign accept0    = grant0;
    assign accept1    = grant1;
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign first_out  = first_q;
    assign source_out = source_q;
    assign busy       = (cnt_q != 2'd0);

endmodule

// File: tb/tb_arb_serial_32_8.sv
// Directed bench for arb_serial_32_8: single word, contention, streaming, mid-word reset, idle hold.
module tb_arb_serial_32_8;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        valid_in0, valid_in1;
    logic [31:0] data_in0, data_in1;
    logic        accept0, accept1;
    logic [7:0]  data_out;
    logic        valid_out, first_out, source_out, busy;

    int checks = 0;
    int errors = 0;

    arb_serial_32_8 dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .valid_in0  (valid_in0),
        .data_in0   (data_in0),
        .valid_in1  (valid_in1),
        .data_in1   (data_in1),
        .accept0    (accept0),
        .accept1    (accept1),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .first_out  (first_out),
        .source_out (source_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic f,
                           input logic s, input logic b);
        chk({tag, ".data"},   {24'h0, data_out},   {24'h0, d});
        chk({tag, ".valid"},  {31'h0, valid_out},  {31'h0, v});
        chk({tag, ".first"},  {31'h0, first_out},  {31'h0, f});
        chk({tag, ".source"}, {31'h0, source_out}, {31'h0, s});
        chk({tag, ".busy"},   {31'h0, busy},       {31'h0, b});
    endtask

    task automatic chk_acc(input string tag, input logic a0, input logic a1);
        #1;
        chk({tag, ".accept0"}, {31'h0, accept0}, {31'h0, a0});
        chk({tag, ".accept1"}, {31'h0, accept1}, {31'h0, a1});
    endtask

    // Protocol monitor: never both accepts, never an accept while busy.
    always @(negedge clk) begin
        checks++;
        if ((accept0 && accept1) || ((accept0 || accept1) && busy)) begin
            errors++;
            $error("FAIL monitor: accept0=%b accept1=%b busy=%b expected no overlap", accept0,
                   accept1, busy);
        end
    end

    logic [7:0] bytes_a [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] bytes_0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] bytes_1 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] bytes_s [3][4] = '{'{8'h01, 8'h02, 8'h03, 8'h04},
                                   '{8'h10, 8'h20, 8'h30, 8'h40},
                                   '{8'hF1, 8'hE2, 8'hD3, 8'hC4}};
    logic [31:0] words_s [3] = '{32'h01020304, 32'h10203040, 32'hF1E2D3C4};

    initial begin
        reset_L   = 1'b0;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        data_in0  = 32'h0;
        data_in1  = 32'h0;
        tick();
        tick();
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_acc("reset", 1'b0, 1'b0);

        // Single word from requester 0.
        reset_L   = 1'b1;
        valid_in0 = 1'b1;
        data_in0  = 32'hA1B2C3D4;
        chk_acc("single.grant", 1'b1, 1'b0);
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b == 0) valid_in0 = 1'b0;
            chk_out($sformatf("single.b%0d", b), bytes_a[b], 1'b1, b == 0, 1'b0, b != 3);
            chk_acc($sformatf("single.b%0d", b), 1'b0, 1'b0);
        end
        tick();
        chk_out("idle_hold", 8'hD4, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_acc("idle_hold", 1'b0, 1'b0);

        // Contention after a fresh reset: 0, 1, 0 with no gap.
        reset_L = 1'b0;
        tick();
        chk_out("reset2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_L   = 1'b1;
        valid_in0 = 1'b1;
        valid_in1 = 1'b1;
        data_in0  = 32'h11223344;
        data_in1  = 32'h55667788;
        chk_acc("cont.grant", 1'b1, 1'b0);
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                tick();
                chk_out($sformatf("cont.w%0d.b%0d", w, b), (w % 2 == 0) ? bytes_0[b] : bytes_1[b],
                        1'b1, b == 0, w % 2 == 1, b != 3);
                if (b == 3) chk_acc($sformatf("cont.w%0d.next", w), w % 2 == 1, w % 2 == 0);
                else        chk_acc($sformatf("cont.w%0d.b%0d", w, b), 1'b0, 1'b0);
            end
        end
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        chk_acc("cont.drop", 1'b0, 1'b0);
        tick();
        chk_out("cont.idle", 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);

        // Requester 1 streams three words back to back.
        valid_in1 = 1'b1;
        data_in1  = words_s[0];
        chk_acc("stream.grant", 1'b0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                tick();
                chk_out($sformatf("stream.w%0d.b%0d", w, b), bytes_s[w][b], 1'b1, b == 0, 1'b1,
                        b != 3);
                if (b == 3 && w < 2) begin
                    data_in1 = words_s[w + 1];
                    chk_acc($sformatf("stream.w%0d.next", w), 1'b0, 1'b1);
                end else begin
                    if (b == 3) valid_in1 = 1'b0;
                    chk_acc($sformatf("stream.w%0d.b%0d", w, b), 1'b0, 1'b0);
                end
            end
        end
        tick();
        chk_out("stream.idle", 8'hC4, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset on the edge after byte 2 of DEADBEEF.
        valid_in0 = 1'b1;
        data_in0  = 32'hDEADBEEF;
        chk_acc("rst.grant", 1'b1, 1'b0);
        tick();
        valid_in0 = 1'b0;
        chk_out("rst.b0", 8'hDE, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("rst.b1", 8'hAD, 1'b1, 1'b0, 1'b0, 1'b1);
        reset_L   = 1'b0;
        valid_in0 = 1'b1;
        valid_in1 = 1'b1;
        data_in0  = 32'hCAFEF00D;
        data_in1  = 32'h12345678;
        tick();
        chk_out("rst.abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_acc("rst.noacc", 1'b0, 1'b0);
        tick();
        chk_out("rst.hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_L = 1'b1;
        chk_acc("rst.release", 1'b1, 1'b0);
        tick();
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        chk_out("rst.new.b0", 8'hCA, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("rst.new.b1", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("rst.new.b2", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("rst.new.b3", 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("rst.idle", 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_acc("rst.idle", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
